mem_write_channel: RTL and testbench

//  Per-channel write front-end that feeds one chN_wr_burst_* port of the round-robin write arbiter.

---
 rtl/mem_write_channel.sv | 181 ++++++++++++++++++
 tb/tb_mem_write_channel.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_write_channel.sv
// mem_write_channel: per-channel write front-end for one port of the round-robin write arbiter.
// Buffers an input word stream in a FIFO, requests a fixed-length burst once a full burst is
// buffered, supplies burst data on demand and walks the DDR address linearly, wrapping at frame end.
//
// Ports:
//   mem_clk, rst_n          clock, synchronous active-low reset
//   frame_sync              pulse: restart frame at FRAME_BASE and flush the FIFO (serviced in idle)
//   in_valid/in_data/in_ready  input word stream
//   fifo_level              words buffered
//   overflow                sticky: word offered while not ready
//   frame_done              pulse after the last burst of a frame
//   wr_burst_*              arbiter channel interface
module mem_write_channel #(
  parameter int unsigned MEM_DATA_BITS = 32,
  parameter int unsigned ADDR_BITS     = 25,
  parameter int unsigned BURST_LEN     = 64,
  parameter int unsigned FIFO_AW       = 9,
  parameter int unsigned FRAME_BASE    = 0,
  parameter int unsigned FRAME_WORDS   = 1024 * 64
) (
  input  logic                     mem_clk,
  input  logic                     rst_n,
  input  logic                     frame_sync,
  input  logic                     in_valid,
  input  logic [MEM_DATA_BITS-1:0] in_data,
  output logic                     in_ready,
  output logic [FIFO_AW:0]         fifo_level,
  output logic                     overflow,
  output logic                     frame_done,
  output logic                     wr_burst_req,
  output logic [9:0]               wr_burst_len,
  output logic [ADDR_BITS-1:0]     wr_burst_addr,
  input  logic                     wr_burst_data_req,
  output logic [MEM_DATA_BITS-1:0] wr_burst_data,
  input  logic                     wr_burst_finish
);

  localparam int unsigned          Depth  = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]     DepthL = (FIFO_AW + 1)'(Depth);
  localparam logic [FIFO_AW:0]     LenL   = (FIFO_AW + 1)'(BURST_LEN);
  localparam logic [9:0]           LenW   = 10'(BURST_LEN);
  localparam logic [31:0]          LenC   = 32'(BURST_LEN);
  localparam logic [31:0]          FrameC = 32'(FRAME_WORDS);
  localparam logic [ADDR_BITS-1:0] BaseA  = ADDR_BITS'(FRAME_BASE);
  localparam logic [ADDR_BITS-1:0] LenA   = ADDR_BITS'(BURST_LEN);

  typedef enum logic [1:0] {StIdle, StReq, StXfer} state_e;

  state_e                   state_q, state_d;
  logic [MEM_DATA_BITS-1:0] mem_q [Depth];
  logic [FIFO_AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]         level_q, level_d;
  logic                     flush_pend_q, flush_pend_d;
  logic                     overflow_q, overflow_d;
  logic                     frame_done_q, frame_done_d;
  logic                     req_q, req_d;
  logic [ADDR_BITS-1:0]     addr_q, addr_d;
  logic [MEM_DATA_BITS-1:0] data_q, data_d;
  logic [9:0]               beat_cnt_q, beat_cnt_d;
  logic [31:0]              word_cnt_q, word_cnt_d;
  logic [31:0]              word_cnt_nxt;
  logic                     push, pop;

  assign in_ready      = (level_q != DepthL) && !flush_pend_q;
  assign fifo_level    = level_q;
  assign overflow      = overflow_q;
  assign frame_done    = frame_done_q;
  assign wr_burst_req  = req_q;
  assign wr_burst_len  = LenW;
  assign wr_burst_addr = addr_q;
  assign wr_burst_data = data_q;

  assign push         = in_valid && in_ready;
  assign pop          = (state_q == StXfer) && wr_burst_data_req && (beat_cnt_q < LenW) &&
                        (level_q != '0);
  assign word_cnt_nxt = word_cnt_q + LenC;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    flush_pend_d = flush_pend_q;
    overflow_d   = overflow_q;
    frame_done_d = 1'b0;
    req_d        = req_q;
    addr_d       = addr_q;
    data_d       = data_q;
    beat_cnt_d   = beat_cnt_q;
    word_cnt_d   = word_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      data_d     = mem_q[rd_ptr_q];
      beat_cnt_d = beat_cnt_q + 10'd1;
    end
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    if (frame_sync) flush_pend_d = 1'b1;
    // Words offered while a flush is pending are dropped silently.
    if (in_valid && !in_ready && !flush_pend_q) overflow_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (flush_pend_q) begin
          // Pending flush wins over a new sync in the same cycle (absorbed).
          wr_ptr_d     = '0;
          rd_ptr_d     = '0;
          level_d      = '0;
          addr_d       = BaseA;
          word_cnt_d   = '0;
          flush_pend_d = 1'b0;
          overflow_d   = 1'b0;
        end else if (level_q >= LenL) begin
          state_d = StReq;
          req_d   = 1'b1;
        end
      end
      StReq: begin
        beat_cnt_d = '0;
        state_d    = StXfer;
      end
      StXfer: begin
        if (wr_burst_finish) begin
          req_d   = 1'b0;
          state_d = StIdle;
          if (word_cnt_nxt == FrameC) begin
            addr_d       = BaseA;
            word_cnt_d   = '0;
            frame_done_d = 1'b1;
          end else begin
            addr_d     = addr_q + LenA;
            word_cnt_d = word_cnt_nxt;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge mem_clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      flush_pend_q <= 1'b0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
      req_q        <= 1'b0;
      addr_q       <= BaseA;
      data_q       <= '0;
      beat_cnt_q   <= '0;
      word_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      flush_pend_q <= flush_pend_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      beat_cnt_q   <= beat_cnt_d;
      word_cnt_q   <= word_cnt_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge mem_clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_mem_write_channel.sv
// Directed bench for mem_write_channel (BURST_LEN=4, FRAME_WORDS=8, FIFO depth 8, base 100).
// A queue holds the words expected to come out of the FIFO in order.
module tb_mem_write_channel;

  localparam int unsigned Base = 100;

  logic        mem_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_sync = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic [3:0]  fifo_level;
  logic        overflow;
  logic        frame_done;
  logic        wr_burst_req;
  logic [9:0]  wr_burst_len;
  logic [24:0] wr_burst_addr;
  logic        wr_burst_data_req = 1'b0;
  logic [31:0] wr_burst_data;
  logic        wr_burst_finish = 1'b0;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_data = '0;

  always #5 mem_clk = ~mem_clk;

  mem_write_channel #(
    .MEM_DATA_BITS(32),
    .ADDR_BITS    (25),
    .BURST_LEN    (4),
    .FIFO_AW      (3),
    .FRAME_BASE   (Base),
    .FRAME_WORDS  (8)
  ) dut (
    .mem_clk          (mem_clk),
    .rst_n            (rst_n),
    .frame_sync       (frame_sync),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .in_ready         (in_ready),
    .fifo_level       (fifo_level),
    .overflow         (overflow),
    .frame_done       (frame_done),
    .wr_burst_req     (wr_burst_req),
    .wr_burst_len     (wr_burst_len),
    .wr_burst_addr    (wr_burst_addr),
    .wr_burst_data_req(wr_burst_data_req),
    .wr_burst_data    (wr_burst_data),
    .wr_burst_finish  (wr_burst_finish)
  );

  task automatic tick();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word expected to be accepted: goes onto the scoreboard.
  task automatic push_word(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    exp_q.push_back(d);
  endtask

  task automatic beat();
    logic [31:0] e;
    wr_burst_data_req = 1'b1;
    tick();
    wr_burst_data_req = 1'b0;
    e = exp_q.pop_front();
    last_data = e;
    chk("burst_data", {32'h0, wr_burst_data}, {32'h0, e});
  endtask

  task automatic finish_pulse();
    wr_burst_finish = 1'b1;
    tick();
    wr_burst_finish = 1'b0;
  endtask

  task automatic chk_level(input string tag);
    chk(tag, 64'(fifo_level), 64'(exp_q.size()));
  endtask

  initial begin
    // Reset
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_req", 64'(wr_burst_req), 64'd0);
    chk("rst_addr", 64'(wr_burst_addr), 64'(Base));
    chk("rst_data", 64'(wr_burst_data), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_fdone", 64'(frame_done), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk_level("rst_level");
    chk("burst_len", 64'(wr_burst_len), 64'd4);

    // T1: one burst worth of data, request timing and data latency
    for (int i = 0; i < 4; i++) push_word(32'hA000_0000 + 32'(i));
    chk("t1_req_early", 64'(wr_burst_req), 64'd0);
    chk_level("t1_level4");
    tick();
    chk("t1_req", 64'(wr_burst_req), 64'd1);
    chk("t1_addr", 64'(wr_burst_addr), 64'(Base));
    tick();
    beat();
    tick();
    beat();
    beat();
    beat();
    chk_level("t1_level0");
    wr_burst_data_req = 1'b1;
    tick();
    wr_burst_data_req = 1'b0;
    chk("t1_extra_data", 64'(wr_burst_data), 64'(last_data));
    chk("t1_req_held", 64'(wr_burst_req), 64'd1);

    // T2: fill while bursting, finish, re-request two cycles later
    for (int i = 0; i < 8; i++) push_word(32'hB000_0000 + 32'(i));
    chk("t2_full_ready", 64'(in_ready), 64'd0);
    chk_level("t2_level8");
    chk("t2_addr_stable", 64'(wr_burst_addr), 64'(Base));
    finish_pulse();
    chk("t2_req_drop", 64'(wr_burst_req), 64'd0);
    chk("t2_addr_adv", 64'(wr_burst_addr), 64'(Base + 4));
    chk("t2_fdone0", 64'(frame_done), 64'd0);
    tick();
    chk("t2_req_again", 64'(wr_burst_req), 64'd1);
    tick();
    for (int i = 0; i < 4; i++) beat();

    // T3: second burst closes the frame
    finish_pulse();
    chk("t3_fdone", 64'(frame_done), 64'd1);
    chk("t3_addr_wrap", 64'(wr_burst_addr), 64'(Base));
    tick();
    chk("t3_fdone_pulse", 64'(frame_done), 64'd0);
    chk("t3_req", 64'(wr_burst_req), 64'd1);
    tick();

    // T4: frame_sync mid-burst with six words queued
    push_word(32'hC000_0000);
    push_word(32'hC000_0001);
    chk_level("t4_level6");
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    chk("t4_ready_low", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    tick();
    in_valid = 1'b0;
    chk("t4_no_ovf", 64'(overflow), 64'd0);
    chk_level("t4_level_hold");
    for (int i = 0; i < 4; i++) beat();
    chk("t4_ready_still_low", 64'(in_ready), 64'd0);
    finish_pulse();
    chk("t4_addr_adv", 64'(wr_burst_addr), 64'(Base + 4));
    chk_level("t4_level2");
    tick();
    exp_q.delete();
    chk_level("t4_flushed");
    chk("t4_addr_base", 64'(wr_burst_addr), 64'(Base));
    chk("t4_ready_back", 64'(in_ready), 64'd1);

    // T5: fill to depth without draining, then overflow attempt
    for (int i = 0; i < 8; i++) push_word(32'hD000_0000 + 32'(i));
    chk("t5_ready0", 64'(in_ready), 64'd0);
    chk_level("t5_level8");
    in_valid = 1'b1;
    in_data  = 32'hEEEE_EEEE;
    tick();
    in_valid = 1'b0;
    chk("t5_ovf", 64'(overflow), 64'd1);
    chk_level("t5_level_hold");
    for (int i = 0; i < 4; i++) beat();
    finish_pulse();
    chk("t5_addr", 64'(wr_burst_addr), 64'(Base + 4));
    chk("t5_ovf_sticky", 64'(overflow), 64'd1);
    tick();
    tick();
    for (int i = 0; i < 4; i++) beat();
    chk("t5_req_xfer", 64'(wr_burst_req), 64'd1);

    // T6: reset mid-burst, stale finish ignored
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    chk("t6_req", 64'(wr_burst_req), 64'd0);
    chk("t6_addr", 64'(wr_burst_addr), 64'(Base));
    chk("t6_data", 64'(wr_burst_data), 64'd0);
    chk("t6_ovf", 64'(overflow), 64'd0);
    chk("t6_ready", 64'(in_ready), 64'd1);
    chk_level("t6_level");
    finish_pulse();
    chk("t6_fin_req", 64'(wr_burst_req), 64'd0);
    chk("t6_fin_addr", 64'(wr_burst_addr), 64'(Base));
    chk("t6_fin_fdone", 64'(frame_done), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
